// File: rtl/alu_result_fifo.sv
// Capture FIFO for registered ALU results and their overflow flags, with a
// saturating overflow counter and a sticky drop flag.
module alu_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_ovf,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_ovf,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           ovf_count,
    output logic                       dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH:0]    mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [WIDTH:0]    head;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign push = in_valid && !full;
    assign pop  = !empty && out_ready;

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign level     = wr_ptr - rd_ptr;

    assign head     = mem[rd_ptr[AW-1:0]];
    assign out_data = empty ? '0 : head[WIDTH-1:0];
    assign out_ovf  = empty ? 1'b0 : head[WIDTH];

    // Storage is never reset; stale contents are hidden by the empty gating.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr[AW-1:0]] <= {in_ovf, in_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ovf_count <= '0;
            dropped   <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ovf_count <= '0;
            dropped   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && in_ovf && (ovf_count != {CNT_W{1'b1}})) begin
                ovf_count <= ovf_count + CNT_W'(1);
            end
            if (in_valid && full) begin
                dropped <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo (DEPTH=4, CNT_W=2 so saturation is reachable).
module tb_alu_result_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic [WIDTH-1:0]  in_data = '0;
    logic              in_ovf = 1'b0;
    logic              in_ready;
    logic              out_valid;
    logic [WIDTH-1:0]  out_data;
    logic              out_ovf;
    logic              out_ready = 1'b0;
    logic [2:0]        level;
    logic [CNT_W-1:0]  ovf_count;
    logic              dropped;

    int n_chk  = 0;
    int n_pass = 0;

    alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_ovf(in_ovf), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ovf(out_ovf), .out_ready(out_ready),
        .level(level), .ovf_count(ovf_count), .dropped(dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input logic o);
        in_valid = 1'b1;
        in_data  = d;
        in_ovf   = o;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    logic [WIDTH-1:0] basic [3];
    logic [WIDTH-1:0] fv [5];
    logic             ovp [7];
    int               sat;

    initial begin
        basic = '{32'h0000_0001, 32'hDEAD_BEEF, 32'hFFFF_FFFF};
        fv    = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004};
        ovp   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        #3;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_dropped", dropped, 0);
        step();
        rst_n = 1'b1;

        // basic order
        for (int i = 0; i < 3; i++) push(basic[i], 1'b0);
        chk("basic_level3", level, 3);
        chk("basic_valid", out_valid, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("basic_pop%0d", i), out_data, basic[i]);
            step();
        end
        out_ready = 1'b0;
        chk("basic_empty_valid", out_valid, 0);
        chk("basic_empty_data", out_data, 0);

        // full and drop
        for (int i = 0; i < 5; i++) begin
            push(fv[i], 1'b0);
            if (i == 3) begin
                chk("full_in_ready", in_ready, 0);
                chk("full_level4", level, 4);
                chk("full_no_drop_yet", dropped, 0);
            end
        end
        chk("drop_sticky", dropped, 1);
        chk("drop_level4", level, 4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("full_pop%0d", i), out_data, fv[i]);
            step();
        end
        out_ready = 1'b0;
        chk("full_drained", out_valid, 0);
        chk("drop_still_set", dropped, 1);
        push(32'h1111_1111, 1'b0);
        push(32'h2222_2222, 1'b0);
        chk("pre_clear_level", level, 2);
        pulse_clear();
        chk("clear_level", level, 0);
        chk("clear_dropped", dropped, 0);
        chk("clear_valid", out_valid, 0);

        // full with simultaneous pop: push must still be dropped
        for (int i = 0; i < 4; i++) push(32'hB000_0000 + i, 1'b0);
        in_valid  = 1'b1;
        in_data   = 32'hB000_0004;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("fullpop_level3", level, 3);
        chk("fullpop_dropped", dropped, 1);
        chk("fullpop_head", out_data, 32'hB000_0001);
        out_ready = 1'b1;
        step(); step(); step();
        out_ready = 1'b0;
        chk("fullpop_no_b4", out_valid, 0);
        pulse_clear();

        // overflow count with saturation, popping continuously
        out_ready = 1'b1;
        sat = 0;
        for (int i = 0; i < 7; i++) begin
            push(32'hC000_0000 + i, ovp[i]);
            if (ovp[i] && sat < 3) sat++;
            chk($sformatf("ovf_out_ovf%0d", i), out_ovf, ovp[i]);
            chk($sformatf("ovf_data%0d", i), out_data, 32'hC000_0000 + i);
            chk($sformatf("ovf_count%0d", i), ovf_count, sat);
        end
        step();
        chk("ovf_sat", ovf_count, 3);
        chk("ovf_drained", out_valid, 0);

        // wrap-around, one in one out per cycle
        for (int i = 0; i < 3 * DEPTH + 1; i++) begin
            push(32'h0000_0100 + i, 1'b0);
            chk($sformatf("wrap_data%0d", i), out_data, 32'h0000_0100 + i);
            chk($sformatf("wrap_level%0d", i), level, 1);
        end
        step();
        chk("wrap_empty", level, 0);
        chk("wrap_no_drop", dropped, 0);
        out_ready = 1'b0;

        // asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) push(32'hD000_0000 + i, 1'b1);
        chk("pre_rst_level", level, 3);
        chk("pre_rst_ovf", ovf_count, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_out_ovf", out_ovf, 0);
        chk("arst_level", level, 0);
        chk("arst_ovf_count", ovf_count, 0);
        chk("arst_dropped", dropped, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_level", level, 0);
        chk("post_rst_valid", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
